// File: rtl/scope_fetch_trace_pkg.sv
// Shared definitions for the fetch-trace scope.
//   state_e    : controller state encoding, also driven on the state port
//   DEPTH_DEF  : default trace buffer depth (entries)
//   PC_W_DEF   : default fetch address width
package scope_fetch_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam int DEPTH_DEF = 16;
  localparam int PC_W_DEF  = 32;

endpackage

// File: rtl/scope_fetch_trace_buf.sv
// Trace storage: DEPTH x PC_W, one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write entry index
//   wr_data : address captured into the entry
//   rd_addr : read entry index
//   rd_data : entry contents, same cycle as rd_addr
module scope_fetch_trace_buf #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 32
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [PC_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [PC_W-1:0]          rd_data
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/scope_fetch_trace_ctrl.sv
// Fetch-trace scope controller. Waits for an arm pulse, latches the
// trigger configuration, captures the first matching fetch address and
// every following valid fetch address up to the configured length, then
// presents the captured entries on a valid/ready read port.
//   clock, reset        : clock and asynchronous active-high reset
//   req_valid, req_pc   : observed frontend fetch requests
//   arm, abort          : start / cancel pulses (abort wins)
//   trig_pc, trig_mask  : trigger address and compare mask (1 = compared)
//   cfg_len             : capture length; 0 or >DEPTH selects DEPTH
//   rd_valid/ready/pc/last : trace read-out handshake
//   state, count        : current state and entries written this capture
module scope_fetch_trace_ctrl
  import scope_fetch_trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [PC_W-1:0]        req_pc,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic [PC_W-1:0]        trig_mask,
  input  logic [$clog2(DEPTH):0] cfg_len,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [PC_W-1:0]        rd_pc,
  output logic                   rd_last,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   len_q, len_d;
  logic [PC_W-1:0] trig_pc_q, trig_pc_d;
  logic [PC_W-1:0] trig_mask_q, trig_mask_d;

  logic            match;
  logic            wr_en;
  logic            rd_fire;
  logic [PC_W-1:0] rd_data;

  assign match    = req_valid && (((req_pc ^ trig_pc_q) & trig_mask_q) == '0);
  assign rd_valid = (state_q == ST_DRAIN) && (rd_ptr_q < count_q);
  assign rd_last  = rd_valid && (rd_ptr_q == count_q - CW'(1));
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    trig_pc_d   = trig_pc_q;
    trig_mask_d = trig_mask_q;
    wr_en       = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d     = ST_ARMED;
            count_d     = '0;
            rd_ptr_d    = '0;
            trig_pc_d   = trig_pc;
            trig_mask_d = trig_mask;
            len_d       = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
          end
        end
        ST_ARMED: begin
          // count_q is zero here, so the trigger lands in entry 0.
          if (match) begin
            wr_en   = 1'b1;
            count_d = CW'(1);
            state_d = (len_q == CW'(1)) ? ST_DRAIN : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (req_valid) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
            if (count_q + CW'(1) == len_q) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_fire) begin
            if (rd_last) begin
              state_d = ST_IDLE;
            end else begin
              rd_ptr_d = rd_ptr_q + CW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      trig_pc_q   <= '0;
      trig_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      trig_pc_q   <= trig_pc_d;
      trig_mask_q <= trig_mask_d;
    end
  end

  scope_fetch_trace_buf #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (req_pc),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  assign rd_pc = rd_data;
  assign state = state_q;
  assign count = count_q;

endmodule

// File: tb/tb_scope_fetch_trace_ctrl.sv
module tb_scope_fetch_trace_ctrl;

  localparam int DEPTH = 16;
  localparam int PC_W  = 32;
  localparam int CW    = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, arm, abort, rd_ready, rd_valid, rd_last;
  logic [31:0]   req_pc, trig_pc, trig_mask, rd_pc;
  logic [CW-1:0] cfg_len, count;
  logic [1:0]    state;

  scope_fetch_trace_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .arm       (arm),
    .abort     (abort),
    .trig_pc   (trig_pc),
    .trig_mask (trig_mask),
    .cfg_len   (cfg_len),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_pc     (rd_pc),
    .rd_last   (rd_last),
    .state     (state),
    .count     (count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: state as a number, captured trace as a queue.
  int          m_state = 0;
  int          m_len   = 0;
  int          m_rd    = 0;
  logic [31:0] m_trig  = '0;
  logic [31:0] m_mask  = '0;
  logic [31:0] m_cap[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_rd_valid();
    return (m_state == 3) && (m_rd < m_cap.size());
  endfunction

  function automatic bit m_rd_last();
    return m_rd_valid() && (m_rd == m_cap.size() - 1);
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = m_rd_valid();
    chk("state", 32'(state), 32'(m_state));
    chk("count", 32'(count), 32'(m_cap.size()));
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("rd_last", 32'(rd_last), 32'(m_rd_last()));
    if (ev) chk("rd_pc", rd_pc, m_cap[m_rd]);
  endtask

  task automatic model_update();
    bit ev, el;
    ev = m_rd_valid();
    el = m_rd_last();
    if (abort) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (arm) begin
          m_trig  = trig_pc;
          m_mask  = trig_mask;
          m_len   = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
          m_cap.delete();
          m_rd    = 0;
          m_state = 1;
        end
        1: if (req_valid && (((req_pc ^ m_trig) & m_mask) == 32'h0)) begin
          m_cap.push_back(req_pc);
          m_state = (m_len == 1) ? 3 : 2;
        end
        2: if (req_valid) begin
          m_cap.push_back(req_pc);
          if (m_cap.size() == m_len) m_state = 3;
        end
        default: if (ev && rd_ready) begin
          if (el) m_state = 0;
          else    m_rd++;
        end
      endcase
    end
  endtask

  task automatic step(input bit a, input bit ab, input bit rv, input logic [31:0] pc, input bit rr);
    arm = a; abort = ab; req_valid = rv; req_pc = pc; rd_ready = rr;
    model_update();
    @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic arm_cfg(input logic [31:0] tp, input logic [31:0] tm, input logic [CW-1:0] len);
    trig_pc = tp; trig_mask = tm; cfg_len = len;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && m_state != 0; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_to_idle", 32'(state), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_pc = 0; arm = 0; abort = 0; rd_ready = 0;
    trig_pc = 0; trig_mask = 0; cfg_len = 0;
    #12 reset = 1'b0;
    @(negedge clock);
    check_outputs();

    // Masked exact trigger, gap cycle inside capture.
    arm_cfg(32'h8000_0100, 32'hFFFF_FFFF, 5'd4);
    trig_pc = 32'h1234_5678; trig_mask = 32'h0; cfg_len = 5'd1;
    step(0, 0, 1, 32'h8000_0200, 0);
    step(0, 0, 1, 32'h8000_0100, 0);
    step(0, 0, 1, 32'h8000_0104, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h8000_0108, 0);
    step(0, 0, 1, 32'h8000_010C, 0);
    chk("len4_first_pc", rd_pc, 32'h8000_0100);
    drain();

    // Length 0 selects full depth; extra requests in DRAIN ignored.
    arm_cfg(32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'(i * 4), 0);
    chk("len0_count", 32'(count), 32'd16);
    drain();

    // Length 1: ARMED straight to DRAIN.
    arm_cfg(32'h40, 32'hFFFF_FFFF, 5'd1);
    step(0, 0, 1, 32'h40, 0);
    chk("len1_state", 32'(state), 32'd3);
    chk("len1_last", 32'(rd_last), 32'd1);
    drain();

    // Stalled drain with ready 1-0-0-1.
    arm_cfg(32'h0, 32'h0, 5'd3);
    step(0, 0, 1, 32'hA0, 0);
    step(0, 0, 1, 32'hA4, 0);
    step(0, 0, 1, 32'hA8, 1);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    drain();

    // Abort mid-capture, arm+abort together, then fresh arm.
    arm_cfg(32'h0, 32'h0, 5'd8);
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 1, 32'h204, 0);
    step(0, 1, 1, 32'h208, 0);
    step(1, 1, 0, 32'h0, 0);
    chk("arm_abort_idle", 32'(state), 32'd0);
    arm_cfg(32'h0, 32'h0, 5'd8);
    chk("rearm_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(32'h300 + i * 4), 0);
    drain();

    // Asynchronous reset in the middle of a drain.
    arm_cfg(32'h0, 32'h0, 5'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(32'h500 + i), 0);
    step(0, 0, 0, 32'h0, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    m_state = 0; m_cap.delete(); m_rd = 0; m_len = 0; m_trig = '0; m_mask = '0;
    #1 reset = 1'b0;
    @(negedge clock);
    check_outputs();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      case ($urandom_range(0, 2))
        0:       trig_mask = 32'h0;
        1:       trig_mask = 32'hFFFF_FFFF;
        default: trig_mask = 32'hFFFF_FFF0;
      endcase
      trig_pc = $urandom;
      cfg_len = CW'($urandom_range(0, 31));
      pc = ($urandom_range(0, 2) == 0) ? $urandom : (m_trig ^ ($urandom & 32'hF));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 9) < 6, pc, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
